// File: rtl/idex_buffer.sv
// ============================================================================
// Module   : idex_buffer
// Purpose  : ID/EX pipeline register. Flush inserts a bubble by clearing the control bits.
//            Optional stall hold is enabled by defining macro IDEX_STALL_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module idex_buffer #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IDEX_FLUSH,
`ifdef IDEX_STALL_EN
   input  logic              IDEX_STALL,
`endif
   input  logic [DATA_W-1:0] RD1,
   input  logic [DATA_W-1:0] RD2,
   input  logic [DATA_W-1:0] signExtendedR2,
   input  logic [3:0]        funct_code_in,
   input  logic [REG_W-1:0]  IFID_RS,
   input  logic [REG_W-1:0]  IFID_RT,
   input  logic              R15_in,
   input  logic              ALUSrc_in,
   input  logic              MemToReg_in,
   input  logic              RegWrite_in,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   input  logic              Branch_in,
   input  logic [1:0]        ALUOP_in,
   output logic [DATA_W-1:0] RD1_out,
   output logic [DATA_W-1:0] RD2_out,
   output logic [DATA_W-1:0] signExtendedR2_out,
   output logic [3:0]        funct_code_out,
   output logic [REG_W-1:0]  RS_out,
   output logic [REG_W-1:0]  RT_out,
   output logic              R15_out,
   output logic              ALUSrc_out,
   output logic              MemToReg_out,
   output logic              RegWrite_out,
   output logic              MemRead_out,
   output logic              MemWrite_out,
   output logic              Branch_out,
   output logic [1:0]        ALUOP_out
);

   logic              w_hold;
   logic [8:0]        w_ctrl_in;
   logic [8:0]        r_ctrl;
   logic [DATA_W-1:0] r_rd1;
   logic [DATA_W-1:0] r_rd2;
   logic [DATA_W-1:0] r_imm;
   logic [3:0]        r_funct;
   logic [REG_W-1:0]  r_rs;
   logic [REG_W-1:0]  r_rt;

   // Flush outranks stall: a flushed edge always captures data and clears control.
`ifdef IDEX_STALL_EN
   assign w_hold = IDEX_STALL & ~IDEX_FLUSH;
`else
   assign w_hold = 1'b0;
`endif

   assign w_ctrl_in = {R15_in, ALUSrc_in, MemToReg_in, RegWrite_in,
                       MemRead_in, MemWrite_in, Branch_in, ALUOP_in};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ctrl <= '0;
      end else if (IDEX_FLUSH) begin
         r_ctrl <= '0;
      end else if (!w_hold) begin
         r_ctrl <= w_ctrl_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_imm   <= '0;
         r_funct <= '0;
         r_rs    <= '0;
         r_rt    <= '0;
      end else if (!w_hold) begin
         r_rd1   <= RD1;
         r_rd2   <= RD2;
         r_imm   <= signExtendedR2;
         r_funct <= funct_code_in;
         r_rs    <= IFID_RS;
         r_rt    <= IFID_RT;
      end
   end

   assign RD1_out            = r_rd1;
   assign RD2_out            = r_rd2;
   assign signExtendedR2_out = r_imm;
   assign funct_code_out     = r_funct;
   assign RS_out             = r_rs;
   assign RT_out             = r_rt;
   assign {R15_out, ALUSrc_out, MemToReg_out, RegWrite_out,
           MemRead_out, MemWrite_out, Branch_out, ALUOP_out} = r_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_idex_buffer.sv
// ============================================================================
// Module   : tb_idex_buffer
// Purpose  : Directed table-driven bench for idex_buffer (stall checks under IDEX_STALL_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_idex_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        IDEX_FLUSH;
`ifdef IDEX_STALL_EN
   logic        IDEX_STALL;
`endif
   logic [15:0] RD1, RD2, signExtendedR2;
   logic [3:0]  funct_code_in;
   logic [3:0]  IFID_RS, IFID_RT;
   logic        R15_in, ALUSrc_in, MemToReg_in, RegWrite_in;
   logic        MemRead_in, MemWrite_in, Branch_in;
   logic [1:0]  ALUOP_in;
   logic [15:0] RD1_out, RD2_out, signExtendedR2_out;
   logic [3:0]  funct_code_out, RS_out, RT_out;
   logic        R15_out, ALUSrc_out, MemToReg_out, RegWrite_out;
   logic        MemRead_out, MemWrite_out, Branch_out;
   logic [1:0]  ALUOP_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   idex_buffer #(.DATA_W(16), .REG_W(4)) dut (
      .clk(clk), .rst(rst), .IDEX_FLUSH(IDEX_FLUSH),
`ifdef IDEX_STALL_EN
      .IDEX_STALL(IDEX_STALL),
`endif
      .RD1(RD1), .RD2(RD2), .signExtendedR2(signExtendedR2),
      .funct_code_in(funct_code_in), .IFID_RS(IFID_RS), .IFID_RT(IFID_RT),
      .R15_in(R15_in), .ALUSrc_in(ALUSrc_in), .MemToReg_in(MemToReg_in),
      .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .Branch_in(Branch_in), .ALUOP_in(ALUOP_in),
      .RD1_out(RD1_out), .RD2_out(RD2_out), .signExtendedR2_out(signExtendedR2_out),
      .funct_code_out(funct_code_out), .RS_out(RS_out), .RT_out(RT_out),
      .R15_out(R15_out), .ALUSrc_out(ALUSrc_out), .MemToReg_out(MemToReg_out),
      .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
      .Branch_out(Branch_out), .ALUOP_out(ALUOP_out)
   );

   // ctrl bit order: {R15, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOP[1:0]}
   typedef struct {
      logic        flush;
      logic [15:0] rd1, rd2, imm;
      logic [3:0]  funct, rs, rt;
      logic [8:0]  ctrl;
      logic [15:0] e_rd1, e_rd2, e_imm;
      logic [3:0]  e_funct, e_rs, e_rt;
      logic [8:0]  e_ctrl;
   } vec_t;

   vec_t vecs[9];

   logic [8:0]  w_octrl;
   logic [59:0] w_odata;
   assign w_octrl = {R15_out, ALUSrc_out, MemToReg_out, RegWrite_out,
                     MemRead_out, MemWrite_out, Branch_out, ALUOP_out};
   assign w_odata = {RD1_out, RD2_out, signExtendedR2_out, funct_code_out, RS_out, RT_out};

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic flush, input logic [15:0] rd1, input logic [15:0] rd2,
                        input logic [15:0] imm, input logic [3:0] funct, input logic [3:0] rs,
                        input logic [3:0] rt, input logic [8:0] ctrl);
      IDEX_FLUSH = flush;
      RD1 = rd1; RD2 = rd2; signExtendedR2 = imm;
      funct_code_in = funct; IFID_RS = rs; IFID_RT = rt;
      {R15_in, ALUSrc_in, MemToReg_in, RegWrite_in,
       MemRead_in, MemWrite_in, Branch_in, ALUOP_in} = ctrl;
   endtask

   function automatic vec_t mk(input logic f, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [3:0] fn, input logic [3:0] s,
                               input logic [3:0] t, input logic [8:0] ct,
                               input logic [15:0] ea, input logic [15:0] eb,
                               input logic [15:0] ec, input logic [3:0] efn,
                               input logic [3:0] es, input logic [3:0] et,
                               input logic [8:0] ect);
      vec_t v;
      v.flush = f; v.rd1 = a; v.rd2 = b; v.imm = c; v.funct = fn; v.rs = s; v.rt = t;
      v.ctrl = ct; v.e_rd1 = ea; v.e_rd2 = eb; v.e_imm = ec; v.e_funct = efn;
      v.e_rs = es; v.e_rt = et; v.e_ctrl = ect;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Capture, flush, alternating flush, extremes.
      vecs[0] = mk(0, 3, 7, 8, 2, 9, 4, 9'b101100011, 3, 7, 8, 2, 9, 4, 9'b101100011);
      vecs[1] = mk(1, 3, 7, 8, 2, 9, 4, 9'b101100011, 3, 7, 8, 2, 9, 4, 9'b000000000);
      vecs[2] = mk(0, 3, 7, 8, 2, 9, 4, 9'b101100011, 3, 7, 8, 2, 9, 4, 9'b101100011);
      vecs[3] = mk(1, 3, 7, 8, 2, 9, 4, 9'b101100011, 3, 7, 8, 2, 9, 4, 9'b000000000);
      vecs[4] = mk(0, 3, 7, 8, 2, 9, 4, 9'b101100011, 3, 7, 8, 2, 9, 4, 9'b101100011);
      vecs[5] = mk(1, 3, 7, 8, 2, 9, 4, 9'b101100011, 3, 7, 8, 2, 9, 4, 9'b000000000);
      vecs[6] = mk(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'hF, 4'hF, 4'hF, 9'h1FF,
                   16'hFFFF, 16'hFFFF, 16'hFFFF, 4'hF, 4'hF, 4'hF, 9'h1FF);
      vecs[7] = mk(1, 16'h8000, 16'h0001, 16'h7FFF, 4'hF, 4'h0, 4'hF, 9'h1FF,
                   16'h8000, 16'h0001, 16'h7FFF, 4'hF, 4'h0, 4'hF, 9'h000);
      vecs[8] = mk(0, 16'h1234, 16'hABCD, 16'hFFFE, 4'h5, 4'hA, 4'h3, 9'b010011100,
                   16'h1234, 16'hABCD, 16'hFFFE, 4'h5, 4'hA, 4'h3, 9'b010011100);

      // Reset held from t=0 with nonzero inputs: edges must have no effect.
      rst = 1'b0;
`ifdef IDEX_STALL_EN
      IDEX_STALL = 1'b0;
`endif
      drive(0, 16'h1111, 16'h2222, 16'h3333, 4'h4, 4'h5, 4'h6, 9'h1FF);
      repeat (3) @(posedge clk);
      #1;
      check("reset_data", {4'h0, w_odata}, 64'h0);
      check("reset_ctrl", {55'h0, w_octrl}, 64'h0);

      // Release mid-cycle: outputs must stay 0 until the next edge.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("release_noglitch", {4'h0, w_odata}, 64'h0);

      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].flush, vecs[i].rd1, vecs[i].rd2, vecs[i].imm,
               vecs[i].funct, vecs[i].rs, vecs[i].rt, vecs[i].ctrl);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_data", i), {4'h0, w_odata},
               {4'h0, vecs[i].e_rd1, vecs[i].e_rd2, vecs[i].e_imm,
                vecs[i].e_funct, vecs[i].e_rs, vecs[i].e_rt});
         check($sformatf("vec%0d_ctrl", i), {55'h0, w_octrl}, {55'h0, vecs[i].e_ctrl});
         @(negedge clk);
      end

      // Two consecutive flush edges give two bubbles, then capture resumes.
      drive(1, 3, 7, 8, 2, 9, 4, 9'b101100011);
      repeat (2) begin
         @(posedge clk); #1;
         check("multi_flush_ctrl", {55'h0, w_octrl}, 64'h0);
      end
      @(negedge clk);
      IDEX_FLUSH = 1'b0;
      @(posedge clk); #1;
      check("flush_resume_ctrl", {55'h0, w_octrl}, {55'h0, 9'b101100011});

      // Latency: RD1 changes right after an edge.
      @(negedge clk);
      RD1 = 16'd3;
      @(posedge clk); #1;
      RD1 = 16'd5;
      #1;
      check("latency_hold", {48'h0, RD1_out}, 64'd3);
      @(posedge clk); #1;
      check("latency_next", {48'h0, RD1_out}, 64'd5);

      // Asynchronous reset mid-cycle after data is loaded.
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      check("async_reset_data", {4'h0, w_odata}, 64'h0);
      check("async_reset_ctrl", {55'h0, w_octrl}, 64'h0);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 3, 7, 8, 2, 9, 4, 9'b101100011);
      @(posedge clk); #1;
      check("post_reset_capture", {55'h0, w_octrl}, {55'h0, 9'b101100011});

`ifdef IDEX_STALL_EN
      @(negedge clk);
      drive(0, 3, 7, 8, 2, 9, 4, 9'b101100011);
      @(posedge clk); #1;
      check("stall_load", {48'h0, RD1_out}, 64'd3);
      @(negedge clk);
      IDEX_STALL = 1'b1;
      drive(0, 5, 7, 8, 2, 9, 4, 9'b010000000);
      repeat (2) begin
         @(posedge clk); #1;
         check("stall_hold_rd1", {48'h0, RD1_out}, 64'd3);
         check("stall_hold_ctrl", {55'h0, w_octrl}, {55'h0, 9'b101100011});
      end
      @(negedge clk);
      IDEX_FLUSH = 1'b1;
      @(posedge clk); #1;
      check("stall_flush_ctrl", {55'h0, w_octrl}, 64'h0);
      check("stall_flush_rd1", {48'h0, RD1_out}, 64'd5);
      @(negedge clk);
      IDEX_STALL = 1'b0;
      IDEX_FLUSH = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/idex_buffer.md
IDEX_BUFFER -- requirements
Module: idex_buffer

Interface
REQ-001 Parameter DATA_W, default 16, width of register-read and immediate data fields.
REQ-002 Parameter REG_W, default 4, width of register-specifier fields.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 IDEX_FLUSH  input  1  synchronous bubble insert (active-high).
REQ-006 RD1, RD2  input  DATA_W  register-file read data.
REQ-007 signExtendedR2  input  DATA_W  sign-extended immediate.
REQ-008 funct_code_in  input  4  instruction function code.
REQ-009 IFID_RS, IFID_RT  input  REG_W  source register numbers from IF/ID.
REQ-010 R15_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in  input  1 each  decode control bits.
REQ-011 ALUOP_in  input  2  ALU operation class.
REQ-012 RD1_out, RD2_out, signExtendedR2_out  output  DATA_W  registered copies of the data inputs.
REQ-013 funct_code_out  output  4; RS_out, RT_out  output  REG_W; registered copies.
REQ-014 R15_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out  output  1 each; ALUOP_out  output  2; registered control.
REQ-015 All outputs driven directly from flops; no combinational input-to-output path.

Function
REQ-016 Latency exactly one cycle: each output equals its input sampled at the previous rising clk edge.
REQ-017 With rst high and IDEX_FLUSH=0, every field captures its input on each rising edge.
REQ-018 With IDEX_FLUSH=1 at a rising edge, all eight control outputs (R15, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOP) load 0.
REQ-019 During flush, data fields (RD1, RD2, signExtendedR2, funct_code, RS, RT) still capture inputs normally.
REQ-020 Flush is level-sampled: asserted on N consecutive edges inserts N bubbles; deassertion resumes normal capture on the next edge.
REQ-021 Unknown (X) on IDEX_FLUSH is not required to be handled; bench drives it to 0/1 before first post-reset edge.
REQ-022 No arithmetic, no state machine; pure pipeline register.

Reset
REQ-023 rst low asynchronously forces every output to 0, independent of clk.
REQ-024 Reset dominates flush and stall; while rst is low, edges have no effect.
REQ-025 On rst release, first capture occurs on the next rising edge; release mid-cycle causes no glitch on outputs.

Configuration
REQ-026 Macro IDEX_STALL_EN: when defined, add input IDEX_STALL (1 bit, active-high) placed after IDEX_FLUSH.
REQ-027 With IDEX_STALL_EN, IDEX_STALL=1 at an edge holds all fields unchanged; IDEX_FLUSH has priority over stall (control cleared, data captured).
REQ-028 Without IDEX_STALL_EN, the port does not exist and behaviour is REQ-016..REQ-020 only.

Verification
REQ-029 Reset: hold rst=0 from t=0, drive nonzero inputs, toggle clk -> all outputs 0; assert rst=0 mid-cycle after loading data -> outputs 0 immediately.
REQ-030 Capture: rst=1, FLUSH=0, RD1=3, RD2=7, imm=8, RS=9, RT=4, funct=2, ALUOP=3, R15=1, MemToReg=1, RegWrite=1, others 0 -> after one edge outputs match exactly.
REQ-031 Flush: same inputs with FLUSH=1 -> after edge all controls and ALUOP 0, RD1_out=3, RD2_out=7, signExtendedR2_out=8, RS_out=9, RT_out=4.
REQ-032 Alternating FLUSH 0/1/0/1 each cycle -> controls alternate loaded/zero cycle by cycle, data constant.
REQ-033 Latency: change RD1 from 3 to 5 just after an edge -> RD1_out stays 3 until next edge, then 5.
REQ-034 With IDEX_STALL_EN: load RD1=3, then STALL=1 with RD1=5 for two edges -> RD1_out stays 3; STALL=1 and FLUSH=1 together -> controls 0, RD1_out=5.
